// File: rtl/marker_tx_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// marker_tx_ctrl : pauses the TX packet writer, injects a two-word marker into
// the TX mux and returns the link after a guard interval.  Rev 1.0
// ----------------------------------------------------------------------------
module marker_tx_ctrl #(
  parameter logic [15:0] IDLE_WORD = 16'h00BC,
  parameter logic [7:0]  MARKER_K  = 8'h1C,
  parameter int          GUARD_CYC = 2,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        TX_CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        MARKER_REQ,
  input  logic [7:0]  MARKER_CODE,
  input  logic        FIBER_READY,
  output logic        FIBER_HOLD,
  output logic        MARKER_EN,
  output logic [15:0] MARKER_DATA,
  output logic [1:0]  MARKER_KCHAR,
  output logic        MARKER_BUSY,
  output logic        MARKER_SENT,
  output logic [15:0] DROP_CNT,
  output logic        TIMEOUT_ERR
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HOLD  = 3'd1;
  localparam logic [2:0] S_SEND0 = 3'd2;
  localparam logic [2:0] S_SEND1 = 3'd3;
  localparam logic [2:0] S_GUARD = 3'd4;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  GUARD_LAST   = 4'(GUARD_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  code_q, code_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]  guard_cnt_q, guard_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic        fiber_hold_q, fiber_hold_d;
  logic        marker_en_q, marker_en_d;
  logic [15:0] marker_data_q, marker_data_d;
  logic [1:0]  marker_kchar_q, marker_kchar_d;
  logic        marker_busy_q, marker_busy_d;
  logic        marker_sent_q, marker_sent_d;

  always_ff @(posedge TX_CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= S_IDLE;
      code_q         <= '0;
      wait_cnt_q     <= '0;
      guard_cnt_q    <= '0;
      drop_cnt_q     <= '0;
      timeout_err_q  <= 1'b0;
      fiber_hold_q   <= 1'b0;
      marker_en_q    <= 1'b0;
      marker_data_q  <= IDLE_WORD;
      marker_kchar_q <= 2'b01;
      marker_busy_q  <= 1'b0;
      marker_sent_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      wait_cnt_q     <= wait_cnt_d;
      guard_cnt_q    <= guard_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
      timeout_err_q  <= timeout_err_d;
      fiber_hold_q   <= fiber_hold_d;
      marker_en_q    <= marker_en_d;
      marker_data_q  <= marker_data_d;
      marker_kchar_q <= marker_kchar_d;
      marker_busy_q  <= marker_busy_d;
      marker_sent_q  <= marker_sent_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    wait_cnt_d    = wait_cnt_q;
    guard_cnt_d   = guard_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    timeout_err_d = timeout_err_q;
    // Any enabled request outside IDLE is lost, including the GUARD exit cycle.
    if (state_q != S_IDLE && MARKER_REQ && ENABLE && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
    case (state_q)
      S_IDLE: begin
        if (MARKER_REQ && ENABLE) begin
          state_d    = S_HOLD;
          code_d     = MARKER_CODE;
          wait_cnt_d = '0;
        end
      end
      S_HOLD: begin
        if (FIBER_READY) begin
          state_d = S_SEND0;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d       = S_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      S_SEND0: state_d = S_SEND1;
      S_SEND1: begin
        state_d     = S_GUARD;
        guard_cnt_d = '0;
      end
      S_GUARD: begin
        if (guard_cnt_q == GUARD_LAST) state_d = S_IDLE;
        else guard_cnt_d = guard_cnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the next state so they line up with the state they describe.
  always_comb begin
    fiber_hold_d   = (state_d != S_IDLE);
    marker_busy_d  = (state_d != S_IDLE);
    marker_en_d    = 1'b0;
    marker_data_d  = IDLE_WORD;
    marker_kchar_d = 2'b01;
    marker_sent_d  = 1'b0;
    case (state_d)
      S_SEND0: begin
        marker_en_d    = 1'b1;
        marker_data_d  = {code_q, MARKER_K};
        marker_kchar_d = 2'b01;
      end
      S_SEND1: begin
        marker_en_d    = 1'b1;
        marker_data_d  = {~code_q, code_q};
        marker_kchar_d = 2'b00;
        marker_sent_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign FIBER_HOLD   = fiber_hold_q;
  assign MARKER_EN    = marker_en_q;
  assign MARKER_DATA  = marker_data_q;
  assign MARKER_KCHAR = marker_kchar_q;
  assign MARKER_BUSY  = marker_busy_q;
  assign MARKER_SENT  = marker_sent_q;
  assign DROP_CNT     = drop_cnt_q;
  assign TIMEOUT_ERR  = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_marker_tx_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_marker_tx_ctrl : directed self-checking bench for marker_tx_ctrl.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_marker_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic        req = 1'b0;
  logic [7:0]  code = 8'h00;
  logic        ready = 1'b0;

  logic        hold, en, busy, sent, terr;
  logic [15:0] data, drops;
  logic [1:0]  kchar;
  logic        to_hold, to_en, to_busy, to_sent, to_terr;
  logic [15:0] to_data, to_drops;
  logic [1:0]  to_kchar;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  marker_tx_ctrl dut (
    .TX_CLK(clk), .RESET(rst), .ENABLE(enable), .MARKER_REQ(req),
    .MARKER_CODE(code), .FIBER_READY(ready), .FIBER_HOLD(hold),
    .MARKER_EN(en), .MARKER_DATA(data), .MARKER_KCHAR(kchar),
    .MARKER_BUSY(busy), .MARKER_SENT(sent), .DROP_CNT(drops),
    .TIMEOUT_ERR(terr)
  );

  marker_tx_ctrl #(.TIMEOUT(16)) dut_to (
    .TX_CLK(clk), .RESET(rst), .ENABLE(enable), .MARKER_REQ(req),
    .MARKER_CODE(code), .FIBER_READY(ready), .FIBER_HOLD(to_hold),
    .MARKER_EN(to_en), .MARKER_DATA(to_data), .MARKER_KCHAR(to_kchar),
    .MARKER_BUSY(to_busy), .MARKER_SENT(to_sent), .DROP_CNT(to_drops),
    .TIMEOUT_ERR(to_terr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req    = 1'b0;
    enable = 1'b1;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " hold"}, hold, 1'b0);
    check_eq({tag, " en"}, en, 1'b0);
    check_eq({tag, " data"}, data, 16'h00BC);
    check_eq({tag, " kchar"}, kchar, 2'b01);
    check_eq({tag, " busy"}, busy, 1'b0);
    check_eq({tag, " sent"}, sent, 1'b0);
  endtask

  // Request at e0 with READY already high; checks the full two-word marker.
  task automatic full_marker(input string tag, input logic [7:0] c);
    code = c; req = 1'b1;
    tick();
    req = 1'b0;
    check_eq({tag, " hold e0"}, hold, 1'b1);
    check_eq({tag, " en e0"}, en, 1'b0);
    tick();
    check_eq({tag, " w0 data"}, data, {c, 8'h1C});
    check_eq({tag, " w0 en/k/sent"}, {en, kchar, sent}, {1'b1, 2'b01, 1'b0});
    tick();
    check_eq({tag, " w1 data"}, data, {~c, c});
    check_eq({tag, " w1 en/k/sent"}, {en, kchar, sent}, {1'b1, 2'b00, 1'b1});
    tick();
    check_eq({tag, " guard en/hold"}, {en, hold, sent}, {1'b0, 1'b1, 1'b0});
    check_eq({tag, " guard data"}, data, 16'h00BC);
    tick();
    check_eq({tag, " guard2 hold"}, hold, 1'b1);
    tick();
    check_eq({tag, " end hold/busy"}, {hold, busy}, 2'b00);
  endtask

  task automatic run_drop_seq(input logic drop_enable, output int sents);
    sents  = 0;
    enable = 1'b1; code = 8'h5A; req = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      req    = (k == 1 || k == 3 || k == 5);
      enable = drop_enable;
      tick();
      sents += int'(sent);
    end
    req = 1'b0; enable = 1'b1;
  endtask

  initial begin
    int sents;

    rst = 1'b1;
    #12;
    check_idle_outputs("rst");
    check_eq("rst drops/terr", {drops, terr}, {16'h0000, 1'b0});
    rst = 1'b0;
    tick();

    // Basic send
    ready = 1'b1;
    full_marker("basic", 8'hA5);

    // Delayed ready: READY rises 37 cycles after the request
    do_reset();
    ready = 1'b0; code = 8'h3C; req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 1; i <= 36; i++) begin
      tick();
      check_eq("delay hold/en", {hold, en}, 2'b10);
    end
    ready = 1'b1;
    tick();
    check_eq("delay w0", {en, data, kchar}, {1'b1, 16'h3C1C, 2'b01});
    tick();
    check_eq("delay w1", {en, data, kchar, sent}, {1'b1, 16'hC33C, 2'b00, 1'b1});
    ready = 1'b0;
    tick();
    check_eq("delay guard", {en, hold}, 2'b01);

    // Timeout on the TIMEOUT=16 instance
    do_reset();
    ready = 1'b0; code = 8'h11; req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check_eq("to waiting", {to_terr, to_hold, to_en}, 3'b010);
    end
    tick();
    check_eq("to fired", {to_terr, to_hold, to_busy, to_en}, 4'b1000);
    check_eq("to drops", to_drops, 16'h0000);
    tick(); tick();
    check_eq("to sticky", {to_terr, to_en}, 2'b10);
    ready = 1'b1; code = 8'h22; req = 1'b1;
    tick();
    req = 1'b0;
    check_eq("to retry hold", to_hold, 1'b1);
    tick();
    check_eq("to retry w0", {to_en, to_data}, {1'b1, 16'h221C});
    tick();
    check_eq("to retry w1", {to_en, to_data, to_sent}, {1'b1, 16'hDD22, 1'b1});
    check_eq("to retry sticky", to_terr, 1'b1);

    // Drops while busy, then with ENABLE low
    do_reset();
    ready = 1'b1;
    run_drop_seq(1'b1, sents);
    check_eq("drop cnt", drops, 16'd3);
    check_eq("drop sents", sents, 1);
    check_eq("drop idle", busy, 1'b0);
    run_drop_seq(1'b0, sents);
    check_eq("drop dis cnt", drops, 16'd3);
    check_eq("drop dis sents", sents, 1);
    enable = 1'b0; req = 1'b1;
    tick();
    req = 1'b0; enable = 1'b1;
    check_eq("dis idle req", {busy, drops}, {1'b0, 16'd3});

    // Reset during word 1
    do_reset();
    ready = 1'b1; code = 8'h77; req = 1'b1;
    tick();
    req = 1'b0;
    tick(); tick();
    check_eq("mid w1", data, 16'h8877);
    rst = 1'b1;
    #2;
    check_idle_outputs("midrst");
    #1;
    rst = 1'b0;
    tick();
    full_marker("postrst", 8'h0F);

    // Saturation: REQ held with READY low; each 1025-cycle period drops 1024
    do_reset();
    ready = 1'b0; req = 1'b1;
    for (int n = 1; n <= 65600; n++) begin
      tick();
      if (n == 65598) check_eq("sat fffe", drops, 16'hFFFE);
      if (n == 65599) check_eq("sat ffff", drops, 16'hFFFF);
      if (n == 65600) check_eq("sat hold", drops, 16'hFFFF);
    end
    req = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/marker_tx_ctrl.md
# marker_tx_ctrl

Sequences loopback/marker insertion into the fiber TX stream. Each marker request pauses the packet writer at a packet boundary. The block then drives a fixed two-word marker through the TX mux's marker path and hands the link back to the writer after a guard interval. It sits between the register/marker-request logic and the TX mux: its outputs feed the mux's MARKER_EN, MARKER_DATA and MARKER_KCHAR inputs, and its FIBER_HOLD/FIBER_READY pair connects to the TX packet writer.

## Interface
- IDLE_WORD, 16'h00BC: word driven on MARKER_DATA when not sending (K28.5 in low byte).
- MARKER_K, 8'h1C: K-character in the low byte of marker word 0 (K28.0).
- GUARD_CYC, 2: cycles FIBER_HOLD stays high after the last marker word (1..15).
- TIMEOUT, 1024: maximum cycles to wait for FIBER_READY (16-bit counter).

- TX_CLK  in  1  TX word clock; single clock domain.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  when 0, new requests are ignored and not counted.
- MARKER_REQ  in  1  single-cycle request pulse.
- MARKER_CODE  in  8  marker code, captured with an accepted MARKER_REQ.
- FIBER_READY  in  1  writer is between packets and emits only idles while FIBER_HOLD is high.
- FIBER_HOLD  out  1  asks the writer to stop at the next packet boundary.
- MARKER_EN  out  1  to the TX mux; selects the marker path.
- MARKER_DATA  out  16  marker word.
- MARKER_KCHAR  out  2  K flags for MARKER_DATA.
- MARKER_BUSY  out  1  high in every state except IDLE.
- MARKER_SENT  out  1  one-cycle pulse when the last marker word is driven.
- DROP_CNT  out  16  saturating count of requests dropped while busy.
- TIMEOUT_ERR  out  1  sticky flag; cleared only by RESET.

## Operation
- States: IDLE, HOLD, SEND0, SEND1, GUARD.
- IDLE:
  - MARKER_REQ && ENABLE: capture MARKER_CODE into code_q, go to HOLD.
  - MARKER_REQ && !ENABLE: ignored.
- HOLD:
  - FIBER_HOLD=1; the wait counter increments every cycle.
  - FIBER_READY=1: go to SEND0.
  - Counter reaches TIMEOUT-1 with FIBER_READY still low: set TIMEOUT_ERR, drop FIBER_HOLD, return to IDLE. The request is abandoned and not counted in DROP_CNT.
- SEND0:
  - MARKER_EN=1, MARKER_DATA={code_q, MARKER_K}, MARKER_KCHAR=2'b01.
  - Always go to SEND1.
- SEND1:
  - MARKER_EN=1, MARKER_DATA={~code_q, code_q}, MARKER_KCHAR=2'b00.
  - MARKER_SENT=1; go to GUARD.
- GUARD:
  - MARKER_EN=0, FIBER_HOLD=1 for GUARD_CYC cycles, then go to IDLE with FIBER_HOLD=0.
- MARKER_DATA/MARKER_KCHAR equal IDLE_WORD/2'b01 whenever MARKER_EN=0.
- MARKER_REQ in any state other than IDLE: DROP_CNT increments if ENABLE=1 and saturates at 16'hFFFF. This includes a request in the IDLE-return cycle of GUARD.
- ENABLE falling mid-sequence does not abort; the sequence completes.
- FIBER_READY falling after SEND0 is entered is ignored.
- All outputs are registered and decoded from the next state, so they change on the edge that enters a state.

## Timing
- Reset values: FIBER_HOLD=0, MARKER_EN=0, MARKER_DATA=IDLE_WORD, MARKER_KCHAR=2'b01, MARKER_BUSY=0, MARKER_SENT=0, DROP_CNT=0, TIMEOUT_ERR=0; state IDLE.
- RESET asserted mid-sequence returns to IDLE immediately; any marker in flight is truncated.
- MARKER_REQ sampled at edge e0: FIBER_HOLD and MARKER_BUSY are high after e0.
- FIBER_READY sampled high at edge e (earliest e = e0+1) produces this sequence:
  - after e: word 0;
  - after e+1: word 1 with MARKER_SENT;
  - after e+2: MARKER_EN=0;
  - after e+2+GUARD_CYC: FIBER_HOLD=0 and MARKER_BUSY=0.
- Minimum request-to-request spacing is GUARD_CYC+4 cycles.
- The mux adds one register stage, so marker words reach the link one cycle after MARKER_EN/MARKER_DATA.
- GUARD_CYC>=1 keeps writer data from colliding with the last marker word in the mux register.

## Test plan
- Basic send: ENABLE=1, FIBER_READY tied high, MARKER_REQ with code 8'hA5.
  - Required: FIBER_HOLD high 1 cycle later.
  - MARKER_EN high 2 cycles carrying 16'hA51C/2'b01 then 16'h5AA5/2'b00.
  - MARKER_SENT pulses on the 16'h5AA5 cycle.
  - FIBER_HOLD falls 2 cycles after MARKER_EN falls.
- Delayed ready: FIBER_READY rises 37 cycles after the request.
  - Required: FIBER_HOLD high throughout, MARKER_EN=0 until the edge after READY, then the normal 2-word marker.
- Timeout: TIMEOUT=16, FIBER_READY held low.
  - Required: TIMEOUT_ERR sets after 16 cycles in HOLD and stays set; FIBER_HOLD drops; MARKER_EN never asserts.
  - A following request with READY high completes normally.
- Drops: 3 MARKER_REQ pulses during one sequence with ENABLE=1.
  - Required: DROP_CNT=3 and exactly one marker is sent.
  - Repeat with ENABLE=0: DROP_CNT unchanged.
- Reset mid-SEND1: assert RESET during word 1.
  - Required: all outputs return to their reset values, including MARKER_DATA=16'h00BC.
  - After release, a new request sends a full marker.
- Saturation: preload 65535 drops, then one more request while busy.
  - Required: DROP_CNT holds 16'hFFFF.
